// File: rtl/fetch_unit.sv
// fetch_unit: issues sequential reads on memory port B and buffers {pc, word} for decode.
// Optional FETCH_BYPASS_EN presents a response straight from memory when the buffer is empty.
module fetch_unit #(
    parameter int                ADDR_W     = 15,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [ADDR_W-1:0] fifoPc   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifoData [FIFO_DEPTH];

    logic              bypass;
    logic              pop;
    logic              popFifo;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] issueAddr;

`ifdef FETCH_BYPASS_EN
    assign bypass = (count_q == '0) && inflight_q && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = !redirect_valid && ((count_q != '0) || bypass);
    assign instr_data  = bypass ? mem_rdata : fifoData[rdPtr];
    assign instr_pc    = bypass ? inflight_pc_q : fifoPc[rdPtr];

    assign pop     = instr_valid && instr_ready;
    assign popFifo = pop && !bypass;
    // A bypassed word that decode takes this cycle never occupies a slot
    assign push    = inflight_q && !redirect_valid && !(bypass && instr_ready);

    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q)
                     - (CNT_W+1)'(pop);
    assign issue = !halt &&
                   (redirect_valid || occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign issueAddr = redirect_valid ? redirect_pc : pc_q;
    assign mem_en    = !reset && issue;
    assign mem_addr  = reset ? RESET_PC : issueAddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            count_q       <= '0;
            rdPtr         <= '0;
            wrPtr         <= '0;
        end else begin
            inflight_q    <= issue;
            inflight_pc_q <= issueAddr;
            pc_q          <= issue ? issueAddr + ADDR_W'(1) : issueAddr;
            if (redirect_valid) begin
                count_q <= '0;
                rdPtr   <= '0;
                wrPtr   <= '0;
            end else begin
                if (push)    wrPtr <= wrPtr + PTR_W'(1);
                if (popFifo) rdPtr <= rdPtr + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(popFifo);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoPc[i]   <= '0;
                fifoData[i] <= '0;
            end
        end else if (push) begin
            fifoPc[wrPtr]   <= inflight_pc_q;
            fifoData[wrPtr] <= mem_rdata;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && count_q == FULL && !popFifo))
            else $error("fetch_unit: capture into full buffer");
        end
    end
`endif

endmodule
